cpu_seq: RTL and testbench

// - Instruction sequencer for the 8-bit register/ALU/memory datapath.
// - Fetches 12-bit microinstructions from an external instruction memory (req/valid handshake).
// - Drives the datapath control fields for exactly one cycle per op.
// - Latches ALU condition codes and executes conditional branches and halt.

---
 rtl/cpu_seq.sv | 243 ++++++++++++++++++++++++
 tb/tb_cpu_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_seq.sv
// -----------------------------------------------------------------------------
// cpu_seq -- microinstruction sequencer for the 8-bit register/ALU/memory
// datapath.
//
// Fetches 12-bit microinstructions over a req/valid handshake. It drives the
// datapath control fields for exactly one cycle per OP. It also latches the ALU
// condition codes and resolves conditional branches and halt.
//
// Instruction word (op = [11:10]):
//    00 OP   : [9]=wrA [8:7]=selA [6:5]=selB [4:3]=aluOp [2]=imm [1:0]=selR
//    01 BR   : [9:7]=cond, [PC_W-1:0]=target
//    10 HALT
//    11 NOP
//
// Parameters:
//    PC_W        program-counter width, legal range 1..7 (a branch target must
//                not overlap the cond field at [9:7])
//
// Ports:
//    clk         rising-edge clock
//    rst         synchronous reset, active-high
//    start       1-cycle pulse; begins execution at PC 0 from IDLE or HALT
//    step        (CPU_SEQ_STEP_EN only) single-step enable for OP/BR
//    imem_req    fetch request, held until imem_valid
//    imem_addr   fetch address (= pc)
//    imem_valid  imem_rdata valid; may coincide with imem_req or come later
//    imem_rdata  instruction word
//    cc          datapath condition codes (combinational from the ALU)
//    wrA         1 = write register file, 0 = memory/output-register store
//    selA, selB  register selects
//    aluOp       ALU operation
//    imm         immediate select (+1 / -1)
//    selR        result mux select
//    busy        high while fetching/executing
//    halted      high in HALT
//    pc          current program counter
//
// Optional feature:
//    `define CPU_SEQ_STEP_EN adds the `step` input. An OP or BR fetched while
//    step is low is parked in ir. During that time imem_req is low and the idle
//    encoding is driven. A later step=1 releases it. One step pulse therefore
//    executes exactly one non-NOP instruction. Without the macro the sequencer
//    runs freely.
// -----------------------------------------------------------------------------
module cpu_seq #(
   parameter int PC_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
`ifdef CPU_SEQ_STEP_EN
   input  logic            step,
`endif
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_valid,
   input  logic [11:0]     imem_rdata,
   input  logic [5:0]      cc,
   output logic            wrA,
   output logic [1:0]      selA,
   output logic [1:0]      selB,
   output logic [1:0]      aluOp,
   output logic            imm,
   output logic [1:0]      selR,
   output logic            busy,
   output logic            halted,
   output logic [PC_W-1:0] pc
);

   // Opcodes
   localparam logic [1:0] OPC_OP   = 2'b00;
   localparam logic [1:0] OPC_BR   = 2'b01;
   localparam logic [1:0] OPC_HALT = 2'b10;
   localparam logic [1:0] OPC_NOP  = 2'b11;

   // Idle control word {wrA, selA, selB, aluOp, imm, selR}. It selects R0 as
   // the result source and writes it back to R0 with no store. Driving it
   // outside EXEC keeps the datapath state unchanged.
   localparam logic [9:0] IDLE_CTRL = 10'b1_00_00_00_0_10;

   // Branch condition that is always taken (cond 6 is never taken).
   localparam logic [2:0] COND_ALWAYS = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_EXEC   = 3'd2,
      S_BRANCH = 3'd3,
      S_HALT   = 3'd4,
      S_HOLD   = 3'd5   // instruction parked waiting for step
   } state_t;

   state_t          state_reg, state_next;
   logic [PC_W-1:0] pc_reg, pc_next;
   logic [11:0]     ir_reg, ir_next;
   logic [5:0]      cc_q_reg, cc_q_next;

   logic [9:0]      ctrl_next;
   logic            req_next;
   logic            busy_next;
   logic            halted_next;

   // Decoded views of the current and incoming instruction.
   logic [1:0]      rdata_op;
   logic [1:0]      ir_op;
   logic [2:0]      br_cond;
   logic [PC_W-1:0] br_target;
   logic [7:0]      cc_ext;
   logic            br_taken;
   logic [PC_W-1:0] pc_inc;
   logic            step_ok;

   assign rdata_op  = imem_rdata[11:10];
   assign ir_op     = ir_reg[11:10];
   assign br_cond   = ir_reg[9:7];
   assign br_target = ir_reg[PC_W-1:0];

   // The latched flags are padded to 8 entries so that cond can index the
   // vector directly. Index 6 reads a constant 0, so cond 6 is never taken.
   // cond 7 is handled separately as "always".
   assign cc_ext   = {2'b00, cc_q_reg};
   assign br_taken = (br_cond == COND_ALWAYS) || cc_ext[br_cond];

   // pc wraps naturally at 2**PC_W.
   assign pc_inc = pc_reg + PC_W'(1);

`ifdef CPU_SEQ_STEP_EN
   assign step_ok = step;
`else
   assign step_ok = 1'b1;
`endif

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         pc_reg    <= '0;
         ir_reg    <= '0;
         cc_q_reg  <= '0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         ir_reg    <= ir_next;
         cc_q_reg  <= cc_q_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and output decode
   // ------------------------------------------------------------------------
   always_comb begin
      state_next  = state_reg;
      pc_next     = pc_reg;
      ir_next     = ir_reg;
      cc_q_next   = cc_q_reg;
      ctrl_next   = IDLE_CTRL;
      req_next    = 1'b0;
      busy_next   = 1'b0;
      halted_next = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               pc_next    = '0;
               state_next = S_FETCH;
            end
         end

         S_FETCH: begin
            busy_next = 1'b1;
            req_next  = 1'b1;
            if (imem_valid) begin
               ir_next = imem_rdata;
               case (rdata_op)
                  OPC_OP:   state_next = step_ok ? S_EXEC : S_HOLD;
                  OPC_BR:   state_next = step_ok ? S_BRANCH : S_HOLD;
                  OPC_HALT: state_next = S_HALT;
                  // NOP: advance and fetch again without leaving FETCH.
                  OPC_NOP:  pc_next = pc_inc;
                  default:  state_next = S_FETCH;
               endcase
            end
         end

         S_EXEC: begin
            busy_next  = 1'b1;
            ctrl_next  = ir_reg[9:0];
            // Flags are captured only here. A branch therefore sees the flags
            // of the most recent OP, never the flags of idle-encoding cycles.
            cc_q_next  = cc;
            pc_next    = pc_inc;
            state_next = S_FETCH;
         end

         S_BRANCH: begin
            busy_next  = 1'b1;
            pc_next    = br_taken ? br_target : pc_inc;
            state_next = S_FETCH;
         end

         S_HALT: begin
            halted_next = 1'b1;
            if (start) begin
               pc_next    = '0;
               state_next = S_FETCH;
            end
         end

`ifdef CPU_SEQ_STEP_EN
         S_HOLD: begin
            // The instruction is already in ir. The fetch is complete, so the
            // request stays low while waiting for step.
            busy_next = 1'b1;
            if (step) begin
               state_next = (ir_op == OPC_BR) ? S_BRANCH : S_EXEC;
            end
         end
`endif

         default: state_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign imem_req  = req_next;
   assign imem_addr = pc_reg;
   assign pc        = pc_reg;
   assign busy      = busy_next;
   assign halted    = halted_next;
   assign {wrA, selA, selB, aluOp, imm, selR} = ctrl_next;

`ifndef CPU_SEQ_STEP_EN
   // Without single-stepping, ir is only decoded through its fields and
   // ir_op is not needed.
   logic unused_ir_op;
   assign unused_ir_op = ^ir_op;
`endif

endmodule

// File: tb/tb_cpu_seq.sv
// -----------------------------------------------------------------------------
// tb_cpu_seq -- directed testbench for cpu_seq (PC_W = 3).
// An instruction ROM model responds with a programmable wait latency. Expected
// EXEC control words are queued when a program is launched. A negedge monitor
// pops and compares them whenever the DUT drives a non-idle control word.
// -----------------------------------------------------------------------------
module tb_cpu_seq;
   localparam int PC_W = 3;
   localparam logic [9:0] IDLE_CTRL = 10'h202;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_valid;
   logic [11:0]     imem_rdata;
   logic [5:0]      cc = 6'h00;
   logic            wrA;
   logic [1:0]      selA, selB, aluOp, selR;
   logic            imm;
   logic            busy, halted;
   logic [PC_W-1:0] pc;
`ifdef CPU_SEQ_STEP_EN
   logic            step = 1'b1;
`endif

   logic [11:0] rom [8];
   int          lat = 0;
   int          wait_cnt = 0;
   logic        force_valid = 1'b0;

   int checks = 0;
   int errors = 0;
   int exec_seen = 0;
   logic [9:0] exp_q[$];
   logic [9:0] ctrl;

   cpu_seq #(.PC_W(PC_W)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
`ifdef CPU_SEQ_STEP_EN
      .step(step),
`endif
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_valid(imem_valid),
      .imem_rdata(imem_rdata),
      .cc(cc),
      .wrA(wrA),
      .selA(selA),
      .selB(selB),
      .aluOp(aluOp),
      .imm(imm),
      .selR(selR),
      .busy(busy),
      .halted(halted),
      .pc(pc)
   );

   always #5 clk = ~clk;

   // ROM with wait states: valid after `lat` cycles of held request.
   assign imem_valid = (imem_req && (wait_cnt >= lat)) || force_valid;
   assign imem_rdata = rom[imem_addr];
   always @(posedge clk) begin
      if (!imem_req || imem_valid) wait_cnt <= 0;
      else                         wait_cnt <= wait_cnt + 1;
   end

   assign ctrl = {wrA, selA, selB, aluOp, imm, selR};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: each non-idle control cycle consumes one expectation.
   always @(negedge clk) begin
      if (!rst && ctrl !== IDLE_CTRL) begin
         exec_seen++;
         if (exp_q.size() == 0) check("exec_unexpected", ctrl, IDLE_CTRL);
         else                   check("exec_fields", ctrl, exp_q.pop_front());
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_halted(input int max, input string tag);
      int n = 0;
      while (!halted && n < max) begin
         @(negedge clk);
         n++;
      end
      check(tag, halted, 1);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) rom[i] = 12'h800;

      // ---- reset and idle ----
      rst = 1'b1;
      tick(2);
      check("rst_req", imem_req, 0);
      check("rst_ctrl", ctrl, IDLE_CTRL);
      rst = 1'b0;
      tick(5);
      check("idle_req", imem_req, 0);
      check("idle_ctrl", ctrl, IDLE_CTRL);
      check("idle_pc", pc, 0);
      check("idle_busy", busy, 0);
      check("idle_halted", halted, 0);

      // ---- single OP then HALT, zero-wait ----
      rom[0] = 12'h2C1;
      rom[1] = 12'h800;
      lat = 0;
      exp_q.push_back(10'h2C1);
      pulse_start();                      // cycle 1: FETCH
      check("op_req_fetch", imem_req, 1);
      check("op_busy", busy, 1);
      tick(1);                            // cycle 2: EXEC
      check("op_exec_ctrl", ctrl, 10'h2C1);
      tick(1);                            // cycle 3: FETCH HALT
      check("op_one_cycle", ctrl, IDLE_CTRL);
      check("op_pc_inc", pc, 1);
      tick(1);                            // cycle 4: HALT
      check("op_halted", halted, 1);
      check("op_halt_busy", busy, 0);
      check("op_sb_empty", exp_q.size(), 0);

      // ---- delayed fetch, start ignored while busy ----
      rom[0] = 12'h0D5;
      lat = 3;
      exp_q.push_back(10'h0D5);
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         check("slow_req_held", imem_req, 1);
         check("slow_addr_stable", imem_addr, 0);
         tick(1);
      end
      check("slow_exec_ctrl", ctrl, 10'h0D5);
      check("slow_req_low_exec", imem_req, 0);
      tick(1);
      check("slow_addr_next", imem_addr, 1);
      pulse_start();                      // lands mid-FETCH; must be ignored
      wait_halted(20, "slow_halt_timeout");
      check("slow_halt_pc", pc, 1);
      check("slow_sb_empty", exp_q.size(), 0);

      // ---- branches ----
      lat = 0;
      rom[0] = 12'h2C1;
      for (int i = 2; i < 8; i++) rom[i] = 12'h800;
      // cond 0 set -> taken
      rom[1] = 12'h405; cc = 6'b000001;
      exp_q.push_back(10'h2C1);
      pulse_start();
      wait_halted(20, "br_taken_timeout");
      check("br_c0_taken_pc", pc, 5);
      // cond 6 never taken
      rom[1] = 12'h705;
      exp_q.push_back(10'h2C1);
      pulse_start();
      wait_halted(20, "br_c6_timeout");
      check("br_c6_pc", pc, 2);
      // cond 0 clear -> not taken
      rom[1] = 12'h405; cc = 6'b000000;
      exp_q.push_back(10'h2C1);
      pulse_start();
      wait_halted(20, "br_c0n_timeout");
      check("br_c0_nt_pc", pc, 2);
      // cond 7 always taken
      rom[1] = 12'h785;
      exp_q.push_back(10'h2C1);
      pulse_start();
      wait_halted(20, "br_c7_timeout");
      check("br_c7_pc", pc, 5);
      // flags only latched in EXEC: cc high except in the EXEC cycle
      rom[1] = 12'h405; cc = 6'h3F;
      exp_q.push_back(10'h2C1);
      pulse_start();                      // cycle 1 FETCH
      tick(1);                            // cycle 2 EXEC
      cc = 6'h00;
      tick(1);
      cc = 6'h3F;
      wait_halted(20, "br_ccq_timeout");
      check("br_ccq_exec_only_pc", pc, 2);
      check("br_sb_empty", exp_q.size(), 0);

      // ---- NOP wrap ----
      for (int i = 0; i < 8; i++) rom[i] = 12'hC00;
      pulse_start();
      for (int i = 0; i < 9; i++) begin
         check("nop_pc_seq", pc, i % 8);
         tick(1);
      end

      // ---- reset during a stalled fetch ----
      lat = 3;
      tick(2);
      check("midrst_req_before", imem_req, 1);
      rst = 1'b1;
      tick(1);
      check("midrst_req_drop", imem_req, 0);
      check("midrst_busy", busy, 0);
      check("midrst_pc", pc, 0);
      rst = 1'b0;
      force_valid = 1'b1;
      tick(3);
      check("late_valid_req", imem_req, 0);
      check("late_valid_busy", busy, 0);
      check("late_valid_pc", pc, 0);
      check("late_valid_ctrl", ctrl, IDLE_CTRL);
      force_valid = 1'b0;

`ifdef CPU_SEQ_STEP_EN
      // ---- single-step ----
      begin
         int e0;
         step = 1'b0;
         lat = 0;
         rom[0] = 12'h2C1; rom[1] = 12'h0D5; rom[2] = 12'h2C1; rom[3] = 12'h800;
         e0 = exec_seen;
         pulse_start();
         tick(10);
         check("step_no_exec", exec_seen, e0);
         check("step_hold_req", imem_req, 0);
         exp_q.push_back(10'h2C1);
         exp_q.push_back(10'h0D5);
         exp_q.push_back(10'h2C1);
         for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            tick(1);
            step = 1'b0;
            tick(4);
            check("step_exec_count", exec_seen, e0 + k + 1);
         end
         check("step_halted", halted, 1);
         check("step_sb_empty", exp_q.size(), 0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
